// File: rtl/alu_result_stage_if.sv
// Bundle of the ALU result stage's upstream, downstream and status signals.
// The stage sits on the slave side; the producer/consumer environment is the master.
interface alu_result_stage_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_cout;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic             sticky_v;
  logic             clr_sticky;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output in_valid, in_result, in_cout, in_ovf, out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_flags, sticky_v, xfer_cnt
  );

  modport slave (
    input  in_valid, in_result, in_cout, in_ovf, out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_flags, sticky_v, xfer_cnt
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: captures result with N/Z/C/V flags, hands it on
// through a main+skid pair so in_ready depends only on state, tracks sticky V and transfers.
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_result_stage_if.slave bus
);

  // {N,Z,C,V}; computed once at capture and carried with the data.
  function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] res,
                                            input logic cout,
                                            input logic ovf);
    calc_flags = {res[WIDTH-1], (res == '0), cout, ovf};
  endfunction

  logic             m_vld_q, m_vld_d;
  logic             s_vld_q, s_vld_d;
  logic [WIDTH-1:0] m_res_q, m_res_d;
  logic [WIDTH-1:0] s_res_q, s_res_d;
  logic [3:0]       m_flg_q, m_flg_d;
  logic [3:0]       s_flg_q, s_flg_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] in_flg;
  logic       accept;
  logic       xfer;

  assign bus.in_ready = ~s_vld_q & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign xfer         = m_vld_q & bus.out_ready;
  assign in_flg       = calc_flags(bus.in_result, bus.in_cout, bus.in_ovf);

  always_comb begin
    m_vld_d  = m_vld_q;
    s_vld_d  = s_vld_q;
    m_res_d  = m_res_q;
    m_flg_d  = m_flg_q;
    s_res_d  = s_res_q;
    s_flg_d  = s_flg_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    // Skid is only ever occupied while main is, so main-empty implies skid-empty.
    if (!m_vld_q) begin
      if (accept) begin
        m_vld_d = 1'b1;
        m_res_d = bus.in_result;
        m_flg_d = in_flg;
      end
    end else if (xfer) begin
      if (s_vld_q) begin
        m_res_d = s_res_q;
        m_flg_d = s_flg_q;
        s_vld_d = 1'b0;
      end else if (accept) begin
        m_res_d = bus.in_result;
        m_flg_d = in_flg;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (accept) begin
      s_vld_d = 1'b1;
      s_res_d = bus.in_result;
      s_flg_d = in_flg;
    end

    // A V=1 transfer beats a coincident clear so the overflow event is never lost.
    if (xfer && m_flg_q[0]) begin
      sticky_d = 1'b1;
    end else if (bus.clr_sticky) begin
      sticky_d = 1'b0;
    end

    if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---- stage register: main slot, sticky flag, transfer counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q  <= 1'b0;
      s_vld_q  <= 1'b0;
      m_res_q  <= '0;
      m_flg_q  <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      m_vld_q  <= m_vld_d;
      s_vld_q  <= s_vld_d;
      m_res_q  <= m_res_d;
      m_flg_q  <= m_flg_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---- skid payload: qualified by s_vld_q, so it needs no reset ----
  always_ff @(posedge clk) begin
    s_res_q <= s_res_d;
    s_flg_q <= s_flg_d;
  end

  assign bus.out_valid  = m_vld_q;
  assign bus.out_result = m_res_q;
  assign bus.out_flags  = m_flg_q;
  assign bus.sticky_v   = sticky_q;
  assign bus.xfer_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random valid/ready traffic
// compared every cycle against a 2-deep FIFO reference model.
module tb_alu_result_stage;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flg;
  } ent_t;

  logic clk = 1'b0;
  logic rst;

  alu_result_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_xfer = 0;

  ent_t       mq[$];
  logic       m_sticky;
  logic [7:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_flags(input int res, input bit cout, input bit ovf);
    bit n, z;
    n = (res >= 128);
    z = (res == 0);
    return {n, z, cout, ovf};
  endfunction

  task automatic check_outputs();
    chk("in_ready", bus.in_ready, (!rst && mq.size() < 2));
    chk("out_valid", bus.out_valid, (mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_result", bus.out_result, mq[0].res);
      chk("out_flags", bus.out_flags, mq[0].flg);
    end
    chk("sticky_v", bus.sticky_v, m_sticky);
    chk("xfer_cnt", bus.xfer_cnt, m_cnt);
  endtask

  // One clock: check at negedge, then advance the model on the posedge.
  task automatic cycle();
    bit acc, xf;
    ent_t e;
    @(negedge clk);
    check_outputs();
    acc = bus.in_valid && !rst && (mq.size() < 2);
    xf  = !rst && (mq.size() > 0) && bus.out_ready;
    e.res = bus.in_result;
    e.flg = ref_flags(int'(bus.in_result), bus.in_cout, bus.in_ovf);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_sticky = 1'b0;
      m_cnt    = 8'd0;
    end else begin
      if (xf && mq[0].flg[0]) m_sticky = 1'b1;
      else if (bus.clr_sticky) m_sticky = 1'b0;
      if (xf) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 8'd1;
        n_xfer++;
      end
      if (acc) mq.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] r, input bit c, input bit o);
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_cout   = c;
    bus.in_ovf    = o;
  endtask

  initial begin
    int start_xfer;
    int guard;
    logic [7:0] start_cnt;

    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
    m_sticky = 1'b0;
    m_cnt    = 8'd0;

    // Reset for two cycles, then release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_result", bus.out_result, 8'h00);
    chk("rst_out_flags", bus.out_flags, 4'h0);
    chk("rst_sticky", bus.sticky_v, 1'b0);
    chk("rst_cnt", bus.xfer_cnt, 8'h00);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", bus.in_ready, 1'b1);

    // Zero result with carry.
    drive(1, 8'h00, 1, 0);
    bus.out_ready = 1'b1;
    cycle();
    chk("zero_valid", bus.out_valid, 1'b1);
    chk("zero_result", bus.out_result, 8'h00);
    chk("zero_flags", bus.out_flags, 4'b0110);
    drive(0, 8'h00, 0, 0);
    cycle();
    chk("zero_cnt", bus.xfer_cnt, 8'd1);

    // Negative of 0x80 overflows.
    drive(1, 8'h80, 0, 1);
    cycle();
    chk("neg80_flags", bus.out_flags, 4'b1001);
    drive(0, 8'h00, 0, 0);
    cycle();
    chk("neg80_sticky", bus.sticky_v, 1'b1);
    bus.clr_sticky = 1'b1;
    cycle();
    bus.clr_sticky = 1'b0;
    chk("clr_sticky", bus.sticky_v, 1'b0);

    // Back-to-back with consumer stalled: fill main and skid.
    bus.out_ready = 1'b0;
    drive(1, 8'h01, 0, 0);
    cycle();
    drive(1, 8'h02, 0, 0);
    cycle();
    chk("stall_in_ready", bus.in_ready, 1'b0);
    chk("stall_res01", bus.out_result, 8'h01);
    drive(1, 8'h03, 0, 0);
    cycle();
    chk("hold_in_ready", bus.in_ready, 1'b0);
    chk("hold_res01", bus.out_result, 8'h01);
    bus.out_ready = 1'b1;
    cycle();
    chk("drain_res02", bus.out_result, 8'h02);
    cycle();
    chk("drain_res03", bus.out_result, 8'h03);
    drive(0, 8'h00, 0, 0);
    cycle();
    chk("drain_empty", bus.out_valid, 1'b0);

    // 256 transfers wrap the counter back to its starting value.
    start_cnt  = m_cnt;
    start_xfer = n_xfer;
    guard = 0;
    while ((n_xfer - start_xfer) < 256 && guard < 600) begin
      drive(1, 8'($urandom), 1'($urandom), 0);
      cycle();
      guard++;
    end
    chk("wrap_count_reached", (n_xfer - start_xfer), 256);
    chk("wrap_cnt", bus.xfer_cnt, start_cnt);
    drive(0, 8'h00, 0, 0);
    repeat (2) cycle();

    // Clear coinciding with a V=1 transfer: set wins.
    bus.out_ready = 1'b0;
    drive(1, 8'h7F, 0, 1);
    cycle();
    drive(0, 8'h00, 0, 0);
    bus.out_ready  = 1'b1;
    bus.clr_sticky = 1'b1;
    cycle();
    bus.clr_sticky = 1'b0;
    chk("set_beats_clr", bus.sticky_v, 1'b1);

    // Reset with both slots full discards them and counts nothing.
    bus.out_ready = 1'b0;
    drive(1, 8'hA5, 0, 0);
    cycle();
    drive(1, 8'h5A, 0, 0);
    cycle();
    chk("full_in_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    drive(0, 8'h00, 0, 0);
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_cnt", bus.xfer_cnt, 8'd0);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 1'($urandom));
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      bus.clr_sticky = ($urandom_range(0, 7) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    drive(0, 8'h00, 0, 0);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
